alu_serial_rx: RTL and testbench

- Serial input deserializer for the ALU datapath. Receives the bit-serial request stream on `sin` that the tester drives, one bit per clock.
- Reassembles 8 data frames and 1 command frame into operands A/B and the operation code.
- Checks frame count, CRC4 and opcode, then presents one decoded request or one error indication per packet to the ALU core.

---
 rtl/alu_serial_rx_if.sv | 28 ++
 rtl/alu_serial_rx.sv | 148 ++++++++++++++
 tb/tb_alu_serial_rx.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_serial_rx_if.sv
`default_nettype none
// ============================================================================
// alu_serial_rx_if : serial request line and decoded-request bus of the
//                    ALU serial deserializer.
// Revision: 1.0
// ============================================================================
interface alu_serial_rx_if;
  logic        sin;
  logic        req_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  op;
  logic [2:0]  err_flags;
  logic        busy;

  // Tester side: drives the serial line, observes decoded requests.
  modport master (
    output sin,
    input  req_valid, A, B, op, err_flags, busy
  );

  // Deserializer side.
  modport slave (
    input  sin,
    output req_valid, A, B, op, err_flags, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_serial_rx.sv
`default_nettype none
// ============================================================================
// alu_serial_rx : deserializes 8 data frames + 1 command frame into A/B/op,
//                 checks frame count, CRC4 and opcode, emits one strobe/packet.
// Revision: 1.0
// ============================================================================
module alu_serial_rx #(
  parameter int DATA_FRAMES = 8,
  parameter int FRAME_BITS  = 11
) (
  input  logic           clk,
  input  logic           rst,
  alu_serial_rx_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TYPE    = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd3;
  localparam logic [2:0] S_DECODE  = 3'd4;

  localparam logic [2:0] c_PAY_LAST    = 3'(FRAME_BITS - 4);
  localparam logic [3:0] c_DATA_FRAMES = 4'(DATA_FRAMES);
  localparam logic [3:0] c_CNT_MAX     = 4'hF;
  localparam logic [3:0] c_POLY        = 4'h3;

  logic [2:0]  state_q, state_d;
  logic        type_q;
  logic [2:0]  bitcnt_q;
  logic [7:0]  shift_q;
  logic [63:0] data_q;
  logic [3:0]  cnt_q;
  logic        frm_err_q;
  logic        req_valid_q;
  logic [31:0] a_q, b_q;
  logic [2:0]  op_q;
  logic [2:0]  err_q;
  logic        w_busy;

  logic [2:0]  w_op_rx;
  logic [3:0]  w_crc_rx;
  logic [3:0]  w_crc_calc;
  logic        w_op_ok;
  logic [2:0]  w_err;

  function automatic logic [3:0] crc4(input logic [67:0] v);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ v[i];
      c  = {c[2:0], 1'b0} ^ (fb ? c_POLY : 4'h0);
    end
    return c;
  endfunction

  // The command payload stays in shift_q through STOP and DECODE.
  assign w_op_rx    = shift_q[6:4];
  assign w_crc_rx   = shift_q[3:0];
  assign w_crc_calc = crc4({data_q, 1'b1, w_op_rx});
  assign w_op_ok    = (w_op_rx == 3'b000) || (w_op_rx == 3'b001) ||
                      (w_op_rx == 3'b100) || (w_op_rx == 3'b101);

  always_comb begin
    w_err = 3'b000;
    if ((cnt_q != c_DATA_FRAMES) || frm_err_q) w_err = 3'b100;
    else if (w_crc_rx != w_crc_calc)           w_err = 3'b010;
    else if (!w_op_ok)                         w_err = 3'b001;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (!bus.sin) state_d = S_TYPE;
      S_TYPE:    state_d = S_PAYLOAD;
      S_PAYLOAD: if (bitcnt_q == 3'd0) state_d = S_STOP;
      S_STOP:    state_d = type_q ? S_DECODE : S_IDLE;
      S_DECODE:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (state_q == S_TYPE) || (state_q == S_PAYLOAD) || (state_q == S_STOP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      type_q      <= 1'b0;
      bitcnt_q    <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 64'h0;
      cnt_q       <= 4'h0;
      frm_err_q   <= 1'b0;
      req_valid_q <= 1'b0;
      a_q         <= 32'h0;
      b_q         <= 32'h0;
      op_q        <= 3'b000;
      err_q       <= 3'b000;
    end else begin
      req_valid_q <= 1'b0;
      case (state_q)
        S_TYPE: begin
          type_q   <= bus.sin;
          bitcnt_q <= c_PAY_LAST;
        end
        S_PAYLOAD: begin
          shift_q  <= {shift_q[6:0], bus.sin};
          bitcnt_q <= bitcnt_q - 3'd1;
        end
        S_STOP: begin
          if (!bus.sin) begin
            frm_err_q <= 1'b1;
          end else if (!type_q) begin
            data_q <= {data_q[55:0], shift_q};
            if (cnt_q != c_CNT_MAX) cnt_q <= cnt_q + 4'd1;
          end
        end
        S_DECODE: begin
          req_valid_q <= 1'b1;
          err_q       <= w_err;
          cnt_q       <= 4'h0;
          frm_err_q   <= 1'b0;
          if (w_err == 3'b000) begin
            b_q  <= data_q[63:32];
            a_q  <= data_q[31:0];
            op_q <= w_op_rx;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_valid = req_valid_q;
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.op        = op_q;
  assign bus.err_flags = err_q;
  assign bus.busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_rx.sv
`default_nettype none
// ============================================================================
// tb_alu_serial_rx : directed + randomized packets against a reference model
//                    built from the packet/CRC rules.
// Revision: 1.0
// ============================================================================
module tb_alu_serial_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   strobes  = 0;
  int   packets  = 0;

  logic [7:0]  pkt_q[$];
  logic [31:0] m_a  = 32'h0;
  logic [31:0] m_b  = 32'h0;
  logic [2:0]  m_op = 3'b000;

  alu_serial_rx_if bus();

  alu_serial_rx #(.DATA_FRAMES(8), .FRAME_BITS(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.req_valid === 1'b1) strobes++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Remainder of M(x)*x^4 divided by x^4+x+1, M = {B, A, 1, op}.
  function automatic logic [3:0] golden_crc(input logic [31:0] b, input logic [31:0] a,
                                            input logic [2:0] op);
    logic [71:0] m;
    m = {b, a, 1'b1, op, 4'h0};
    for (int i = 71; i >= 4; i--)
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    return m[3:0];
  endfunction

  task automatic bit_out(input logic b);
    bus.sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic t, input logic [7:0] p, input logic stop);
    bit_out(1'b0);
    bit_out(t);
    for (int i = 7; i >= 0; i--) bit_out(p[i]);
    bit_out(stop);
  endtask

  task automatic load_ba(input logic [31:0] b, input logic [31:0] a);
    logic [63:0] v;
    v = {b, a};
    pkt_q.delete();
    for (int i = 7; i >= 0; i--) pkt_q.push_back(v[i*8 +: 8]);
  endtask

  task automatic run_packet(input string tag, input logic [2:0] op, input logic [3:0] crc,
                            input int bad_idx);
    int          n;
    logic        framing;
    logic [63:0] ba;
    logic [2:0]  exp_err;
    logic        seen;
    n       = pkt_q.size();
    framing = 1'b0;
    for (int i = 0; i < n; i++) begin
      send_frame(1'b0, pkt_q[i], (i == bad_idx) ? 1'b0 : 1'b1);
      if (i == bad_idx) framing = 1'b1;
    end
    send_frame(1'b1, {1'b0, op, crc}, 1'b1);
    bus.sin = 1'b1;
    packets++;

    ba = 64'h0;
    if (n >= 8)
      for (int k = 0; k < 8; k++) ba = {ba[55:0], pkt_q[n-8+k]};
    if (n != 8 || framing)                              exp_err = 3'b100;
    else if (crc !== golden_crc(ba[63:32], ba[31:0], op)) exp_err = 3'b010;
    else if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101})) exp_err = 3'b001;
    else begin
      exp_err = 3'b000;
      m_b  = ba[63:32];
      m_a  = ba[31:0];
      m_op = op;
    end

    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.req_valid === 1'b1) seen = 1'b1;
    end
    chk({tag, "_valid"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({tag, "_err"}, 64'(bus.err_flags), 64'(exp_err));
      chk({tag, "_A"},   64'(bus.A),  64'(m_a));
      chk({tag, "_B"},   64'(bus.B),  64'(m_b));
      chk({tag, "_op"},  64'(bus.op), 64'(m_op));
      @(negedge clk);
      chk({tag, "_pulse"}, 64'(bus.req_valid), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] rb, ra;
    logic [2:0]  rop;
    logic [3:0]  rcrc;
    int          s0;

    bus.sin = 1'b1;
    rst     = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and idle line
    chk("rst_valid", 64'(bus.req_valid), 64'd0);
    chk("rst_A",     64'(bus.A),         64'd0);
    chk("rst_B",     64'(bus.B),         64'd0);
    chk("rst_op",    64'(bus.op),        64'd0);
    chk("rst_err",   64'(bus.err_flags), 64'd0);
    repeat (100) bit_out(1'b1);
    chk("idle_strobes", 64'(strobes),  64'd0);
    chk("idle_busy",    64'(bus.busy), 64'd0);

    // All-zero packets: op AND, op ADD, then a bad CRC
    load_ba(32'h0, 32'h0);
    run_packet("zero_and", 3'b000, 4'hB, -1);
    run_packet("zero_add", 3'b100, 4'h7, -1);
    run_packet("zero_badcrc", 3'b000, 4'hC, -1);

    // Frame-count errors: 7, 9 and 0 data frames
    load_ba($urandom, $urandom);
    void'(pkt_q.pop_back());
    run_packet("seven", 3'b100, 4'h0, -1);
    load_ba($urandom, $urandom);
    pkt_q.push_back(8'($urandom));
    run_packet("nine", 3'b000, golden_crc({pkt_q[1], pkt_q[2], pkt_q[3], pkt_q[4]},
                                          {pkt_q[5], pkt_q[6], pkt_q[7], pkt_q[8]}, 3'b000), -1);
    pkt_q.delete();
    run_packet("none", 3'b000, 4'h0, -1);

    // Invalid opcode with a good CRC, then SUB
    load_ba(32'hFFFF_FFFF, 32'h1234_5678);
    run_packet("op111", 3'b111, golden_crc(32'hFFFF_FFFF, 32'h1234_5678, 3'b111), -1);
    run_packet("sub",   3'b101, golden_crc(32'hFFFF_FFFF, 32'h1234_5678, 3'b101), -1);

    // Stop bit of frame 3 forced low
    run_packet("badstop", 3'b101, golden_crc(32'hFFFF_FFFF, 32'h1234_5678, 3'b101), 2);

    // Reset in the middle of the 4th data frame
    load_ba($urandom, $urandom);
    for (int i = 0; i < 3; i++) send_frame(1'b0, pkt_q[i], 1'b1);
    bit_out(1'b0);
    chk("mid_busy", 64'(bus.busy), 64'd1);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.sin = 1'b1;
    m_a = 32'h0; m_b = 32'h0; m_op = 3'b000;
    chk("mid_rst_A",    64'(bus.A),    64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    bit_out(1'b1);
    bit_out(1'b1);
    s0 = strobes;
    rb = $urandom; ra = $urandom;
    load_ba(rb, ra);
    run_packet("after_rst", 3'b100, golden_crc(rb, ra, 3'b100), -1);
    repeat (3) @(negedge clk);
    chk("after_rst_strobes", 64'(strobes), 64'(s0 + 1));

    // Randomized packets, occasionally corrupted CRC
    for (int it = 0; it < 8; it++) begin
      rb   = $urandom;
      ra   = $urandom;
      rop  = 3'($urandom_range(0, 7));
      rcrc = golden_crc(rb, ra, rop);
      if ($urandom_range(0, 3) == 0) rcrc = rcrc ^ 4'($urandom_range(1, 15));
      load_ba(rb, ra);
      run_packet("rand", rop, rcrc, -1);
      repeat ($urandom_range(0, 3)) bit_out(1'b1);
    end

    repeat (5) @(negedge clk);
    chk("total_strobes", 64'(strobes), 64'(packets));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
